// File: rtl/flip_pkg.sv
// Shared constants and types for the flip toggle register bank.
package flip_pkg;

  localparam int unsigned FLIP_DEFAULT_WIDTH = 1;
  localparam logic        FLIP_RST_BIT       = 1'b0;

  typedef logic [FLIP_DEFAULT_WIDTH-1:0] flip_state_t;

  localparam flip_state_t FLIP_DEFAULT_RESET = {FLIP_DEFAULT_WIDTH{FLIP_RST_BIT}};

  // Next state of one toggle bit; reset wins over the toggle request.
  function automatic logic tff_next(input logic q, input logic t,
                                    input logic rst, input logic rst_val);
    logic nxt;
    if (rst) begin
      nxt = rst_val;
    end else begin
      nxt = q ^ t;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/flip_tff_cell.sv
// One-bit toggle register with synchronous reset to a supplied value.
module tff_cell
  import flip_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic t_i,
  input  logic rst_val_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // Next-state selection: reset value or toggled current state.
  always_comb begin
    q_d = tff_next(q_q, t_i, reset_i, rst_val_i);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/flip.sv
// Bank of WIDTH independent toggle flip-flops with registered q and complement q_n.
module flip
  import flip_pkg::*;
#(
  parameter int unsigned       WIDTH     = FLIP_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{FLIP_RST_BIT}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      tff_cell u_cell (
        .clk_i     (clk),
        .reset_i   (reset),
        .t_i       (t[gi]),
        .rst_val_i (RESET_VAL[gi]),
        .q_o       (q[gi])
      );
    end
  endgenerate

  assign q_n = ~q;

endmodule

// File: tb/tb_flip.sv
// Scoreboard bench for flip: a default 1-bit instance and a 4-bit instance with reset value 1010.
module tb_flip;
  import flip_pkg::*;

  localparam logic [3:0] RV4 = 4'b1010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  flip_state_t t1 = '0;
  flip_state_t q1, qn1;
  logic [3:0]  t4 = 4'b0000;
  logic [3:0]  q4, qn4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       e1;
    logic [3:0] e4;
  } exp_t;

  exp_t exp_q[$];

  // Model state: number of toggles seen per bit since the last reset.
  int cnt1 = 0;
  int cnt4[4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  flip u_dut1 (
    .clk   (clk),
    .reset (reset),
    .t     (t1),
    .q     (q1),
    .q_n   (qn1)
  );

  flip #(.WIDTH(4), .RESET_VAL(RV4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .t     (t4),
    .q     (q4),
    .q_n   (qn4)
  );

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Apply one cycle of stimulus and push what q must be after the next edge.
  task automatic drive(input logic r, input logic tv1, input logic [3:0] tv4, input logic glitch);
    exp_t e;
    if (glitch) begin
      reset = ~r;
      #1;
    end
    reset = r;
    t1    = tv1;
    t4    = tv4;
    if (r) begin
      cnt1 = 0;
      for (int i = 0; i < 4; i++) cnt4[i] = 0;
    end else begin
      cnt1 += int'(tv1);
      for (int i = 0; i < 4; i++) cnt4[i] += int'(tv4[i]);
    end
    e.e1 = 1'(cnt1 % 2);
    for (int i = 0; i < 4; i++) e.e4[i] = RV4[i] ^ 1'(cnt4[i] % 2);
    exp_q.push_back(e);
  endtask

  // Monitor: compare just after each edge, then again late in the cycle to confirm q held.
  initial begin
    exp_t cur;
    bit   have = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cur  = exp_q.pop_front();
        have = 1'b1;
        check4("q1",   {3'b000, q1},  {3'b000, cur.e1});
        check4("qn1",  {3'b000, qn1}, {3'b000, ~cur.e1});
        check4("q4",   q4,  cur.e4);
        check4("qn4",  qn4, ~cur.e4);
      end
      #7;
      if (have) begin
        check4("q1_hold", {3'b000, q1}, {3'b000, cur.e1});
        check4("q4_hold", q4, cur.e4);
      end
    end
  end

  initial begin
    logic       r;
    logic       tv1;
    logic [3:0] tv4;
    drive(1'b1, 1'b0, 4'b0000, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 4'b0110, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 4'b0000, 1'b0);
    @(negedge clk); drive(1'b0, 1'b0, 4'b0000, 1'b1);
    @(negedge clk); drive(1'b0, 1'b0, 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(1'b0, 1'b1, 4'b0000, 1'b0);
    end
    @(negedge clk); drive(1'b1, 1'b1, 4'b1111, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 300; k++) begin
      r   = ($urandom_range(15) == 0);
      tv1 = 1'($urandom_range(1));
      tv4 = 4'($urandom_range(15));
      @(negedge clk); drive(r, tv1, tv4, ($urandom_range(3) == 0));
    end
    @(negedge clk);
    reset = 1'b0;
    t1    = '0;
    t4    = 4'b0000;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
